forwarding_hazard_unit: RTL and testbench
=========================================

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 4, register-index width.
REQ-002 SHALL have parameter PC_REG, default 15, register index that is never forwarded.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 RA1_D, RA2_D  input  REG_BITS each  decode-stage source register indices.
REQ-007 WA_D  input  REG_BITS  decode-stage destination index.
REQ-008 REG_WRITE_D  input  1  decode instruction writes WA_D.
REQ-009 MEM_TO_REG_D  input  1  decode instruction is a load.
REQ-010 BRANCH_TAKEN_E  input  1  execute-stage branch taken.
REQ-011 FORWARD_AE, FORWARD_BE  output  2 each  execute-stage select for the four-input operand muxes.
REQ-012 STALL_D  output  1  hold fetch/decode registers.
REQ-013 FLUSH_D  output  1  clear decode register.

Function
REQ-014 SHALL keep three internal stage tags (E, M, W), each holding {valid, reg_write, mem_to_reg, wa}.
REQ-015 On each edge, tags SHALL advance: W<=M, M<=E, E<=decode fields; E SHALL load a bubble (all zero) when STALL_D or BRANCH_TAKEN_E is high.
REQ-016 Select encoding SHALL be 00 = register file, 01 = W-stage result, 10 = M-stage ALU result, 11 = reserved, never driven.
REQ-017 For each source, the next select SHALL be 10 if tag E is valid, reg_write is set, not a load, wa matches, and wa != PC_REG; otherwise 01 if tag M is valid, reg_write is set, wa matches, and wa != PC_REG; otherwise 00.
REQ-018 FORWARD_AE/BE SHALL be registered: the value computed in decode appears on the cycle the instruction occupies execute (latency 1).
REQ-019 FORWARD_AE/BE SHALL be loaded with 00 whenever E loads a bubble.
REQ-020 STALL_D SHALL be combinational and high when tag E is a valid load with wa equal to RA1_D or RA2_D and wa != PC_REG.
REQ-021 A load-use stall SHALL last exactly one cycle; after it, the load sits in M and the dependent instruction receives select 01.
REQ-022 FLUSH_D SHALL equal BRANCH_TAKEN_E.
REQ-023 When BRANCH_TAKEN_E and a stall condition coincide, the branch SHALL win: STALL_D low, E bubbled, FLUSH_D high.
REQ-024 RA1_D == RA2_D SHALL yield identical selects on both outputs.
REQ-025 A bubble or invalid tag SHALL never match, including for index 0.

Reset
REQ-026 RESET_N low SHALL immediately clear all tags to invalid and FORWARD_AE/BE to 00.
REQ-027 STALL_D and FLUSH_D SHALL evaluate low during reset.
REQ-028 Reset asserted mid-stall SHALL abort the stall; the first cycle after release SHALL behave as an empty pipeline.
REQ-029 Reset release SHALL be synchronized externally; the block SHALL assume release is clean relative to CLK.

Configuration
REQ-030 With macro HAZARD_STATS_EN defined, the block SHALL add output STALL_COUNT (16 bits).
REQ-031 STALL_COUNT SHALL increment on each cycle STALL_D is high, saturate at 16'hFFFF, and reset to 0.
REQ-032 Without HAZARD_STATS_EN, the port and counter SHALL be absent, with behaviour otherwise identical.

Structure
REQ-033 Shared package hazard_pkg SHALL hold the fwd_sel_t enum (FWD_RF, FWD_WB, FWD_MEM), the stage_tag_t struct, and the PC_REG default constant.
REQ-034 One sub-module, stage_tag_register, SHALL implement a single tag flop with async reset and bubble-load, instantiated three times.
REQ-035 Selects SHALL connect directly to the SELECT ports of the operand mux instances.

Verification
REQ-036 ADD R1 then ADD R2,R1,R3 back-to-back -> FORWARD_AE=10 in the second instruction's execute cycle.
REQ-037 ADD R1, NOP, SUB R4,R5,R1 -> FORWARD_BE=01, FORWARD_AE=00.
REQ-038 LDR R2, then ADD R3,R2,R2 -> STALL_D high one cycle, then FORWARD_AE=FORWARD_BE=01, STALL_COUNT=1 when enabled.
REQ-039 Load-use stall with BRANCH_TAKEN_E in the same cycle -> STALL_D=0, FLUSH_D=1, selects 00 next cycle.
REQ-040 Write to R15 followed by a read of R15 -> selects stay 00; RESET_N pulsed mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding select encoding, stage tag layout and forward-select helper.
package hazard_pkg;
   localparam int PC_REG_DEFAULT = 15;
   localparam int WA_W = 8;
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;
   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_to_reg;
      logic [WA_W-1:0] wa;
   } stage_tag_t;
   // e is the instruction one ahead of decode, m the one two ahead
   function automatic fwd_sel_t fwd_select(stage_tag_t e, stage_tag_t m, logic [WA_W-1:0] ra, logic [WA_W-1:0] pc);
      return (e.valid && e.reg_write && !e.mem_to_reg && e.wa == ra && e.wa != pc) ? FWD_MEM :
             (m.valid && m.reg_write && m.wa == ra && m.wa != pc) ? FWD_WB : FWD_RF;
   endfunction
endpackage

// File: rtl/stage_tag_register.sv
// stage_tag_register: one pipeline stage tag flop with async clear and bubble load.
module stage_tag_register
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bubble,
   input  stage_tag_t d,
   output stage_tag_t q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else q <= bubble ? '0 : d;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: operand forwarding selects, load-use stall and branch flush.
// Optional macro HAZARD_STATS_EN adds a saturating STALL_COUNT output.
module forwarding_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_BITS = 4,
   parameter int PC_REG   = PC_REG_DEFAULT
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [REG_BITS-1:0] RA1_D,
   input  logic [REG_BITS-1:0] RA2_D,
   input  logic [REG_BITS-1:0] WA_D,
   input  logic                REG_WRITE_D,
   input  logic                MEM_TO_REG_D,
   input  logic                BRANCH_TAKEN_E,
   output logic [1:0]          FORWARD_AE,
   output logic [1:0]          FORWARD_BE,
   output logic                STALL_D,
   output logic                FLUSH_D
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]         STALL_COUNT
`endif
);
   localparam logic [WA_W-1:0] PC_WA = WA_W'(PC_REG);
   stage_tag_t tag_d, tag_e, tag_m, tag_w;
   fwd_sel_t   sel_a, sel_b;
   logic       bubble, load_use;
   logic [WA_W-1:0] ra1, ra2;
   always_comb begin
      ra1      = WA_W'(RA1_D);
      ra2      = WA_W'(RA2_D);
      tag_d    = '{valid: 1'b1, reg_write: REG_WRITE_D, mem_to_reg: MEM_TO_REG_D, wa: WA_W'(WA_D)};
      load_use = tag_e.valid && tag_e.mem_to_reg && tag_e.wa != PC_WA && (tag_e.wa == ra1 || tag_e.wa == ra2);
      STALL_D  = RESET_N && !BRANCH_TAKEN_E && load_use;
      FLUSH_D  = RESET_N && BRANCH_TAKEN_E;
      bubble   = STALL_D || BRANCH_TAKEN_E;
      sel_a    = fwd_select(tag_e, tag_m, ra1, PC_WA);
      sel_b    = fwd_select(tag_e, tag_m, ra2, PC_WA);
   end
   stage_tag_register u_tag_e (.clk(CLK), .rst_n(RESET_N), .bubble(bubble), .d(tag_d), .q(tag_e));
   stage_tag_register u_tag_m (.clk(CLK), .rst_n(RESET_N), .bubble(1'b0),   .d(tag_e), .q(tag_m));
   stage_tag_register u_tag_w (.clk(CLK), .rst_n(RESET_N), .bubble(1'b0),   .d(tag_m), .q(tag_w));
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         FORWARD_AE <= FWD_RF;
         FORWARD_BE <= FWD_RF;
      end else begin
         FORWARD_AE <= bubble ? FWD_RF : sel_a;
         FORWARD_BE <= bubble ? FWD_RF : sel_b;
      end
   // W only retires the write-back stage; it must always trail M by one cycle
   a_w_follows_m: assert property (@(posedge CLK) disable iff (!RESET_N) tag_w == $past(tag_m));
`ifdef HAZARD_STATS_EN
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) STALL_COUNT <= '0;
      else if (STALL_D && STALL_COUNT != 16'hFFFF) STALL_COUNT <= STALL_COUNT + 16'd1;
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed hazard scenarios, per-cycle model comparison plus literal checks.
module tb_forwarding_hazard_unit;
   logic       CLK = 0, RESET_N = 0;
   logic [3:0] RA1_D = 0, RA2_D = 0, WA_D = 0;
   logic       REG_WRITE_D = 0, MEM_TO_REG_D = 0, BRANCH_TAKEN_E = 0;
   logic [1:0] FORWARD_AE, FORWARD_BE;
   logic       STALL_D, FLUSH_D;
`ifdef HAZARD_STATS_EN
   logic [15:0] STALL_COUNT;
`endif
   int n_chk = 0, n_fail = 0;
   bit active = 0;

   forwarding_hazard_unit dut (
      .CLK(CLK), .RESET_N(RESET_N), .RA1_D(RA1_D), .RA2_D(RA2_D), .WA_D(WA_D),
      .REG_WRITE_D(REG_WRITE_D), .MEM_TO_REG_D(MEM_TO_REG_D), .BRANCH_TAKEN_E(BRANCH_TAKEN_E),
      .FORWARD_AE(FORWARD_AE), .FORWARD_BE(FORWARD_BE), .STALL_D(STALL_D), .FLUSH_D(FLUSH_D)
`ifdef HAZARD_STATS_EN
      , .STALL_COUNT(STALL_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   // Model: the two instructions issued ahead of decode (ex = next ahead, mem = two ahead)
   typedef struct {bit v; bit rw; bit ld; int wa;} ins_t;
   ins_t ex, mem;
   int exp_fa, exp_fb, exp_cnt;

   function automatic int src_sel(int ra);
      if (ex.v && ex.rw && !ex.ld && ex.wa == ra && ra != 15) return 2;
      if (mem.v && mem.rw && mem.wa == ra && ra != 15) return 1;
      return 0;
   endfunction

   function automatic bit want_stall();
      return RESET_N && !BRANCH_TAKEN_E && ex.v && ex.ld && ex.wa != 15 &&
             (ex.wa == int'(RA1_D) || ex.wa == int'(RA2_D));
   endfunction

   always @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         ex <= '{default: 0};
         mem <= '{default: 0};
         exp_fa <= 0;
         exp_fb <= 0;
         exp_cnt <= 0;
      end else begin
         exp_fa <= (want_stall() || BRANCH_TAKEN_E) ? 0 : src_sel(int'(RA1_D));
         exp_fb <= (want_stall() || BRANCH_TAKEN_E) ? 0 : src_sel(int'(RA2_D));
         mem <= ex;
         ex <= (want_stall() || BRANCH_TAKEN_E) ? '{default: 0} : '{v: 1, rw: REG_WRITE_D, ld: MEM_TO_REG_D, wa: int'(WA_D)};
         if (want_stall() && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
      end

   task automatic chk(string name, int act, int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge CLK)
      if (active) begin
         chk("model_fwd_ae", FORWARD_AE, exp_fa);
         chk("model_fwd_be", FORWARD_BE, exp_fb);
         chk("model_stall_d", STALL_D, want_stall());
         chk("model_flush_d", FLUSH_D, RESET_N && BRANCH_TAKEN_E);
`ifdef HAZARD_STATS_EN
         chk("model_stall_count", STALL_COUNT, exp_cnt);
`endif
      end

   task automatic drive(int ra1, int ra2, int wa, bit rw, bit ld, bit br);
      RA1_D = 4'(ra1);
      RA2_D = 4'(ra2);
      WA_D = 4'(wa);
      REG_WRITE_D = rw;
      MEM_TO_REG_D = ld;
      BRANCH_TAKEN_E = br;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic nops(int n);
      drive(0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   initial begin
      repeat (2) tick();
      chk("reset_fwd_ae", FORWARD_AE, 0);
      chk("reset_stall", STALL_D, 0);
      RESET_N = 1;
      active = 1;
      // ADD R1 ; ADD R2,R1,R3
      drive(0, 0, 1, 1, 0, 0); tick();
      drive(1, 3, 2, 1, 0, 0); tick();
      chk("back2back_ae", FORWARD_AE, 2);
      chk("back2back_be", FORWARD_BE, 0);
      nops(2);
      // ADD R1 ; NOP ; SUB R4,R5,R1
      drive(0, 0, 1, 1, 0, 0); tick();
      nops(1);
      drive(5, 1, 4, 1, 0, 0); tick();
      chk("gap_ae", FORWARD_AE, 0);
      chk("gap_be", FORWARD_BE, 1);
      nops(2);
      // LDR R2 ; ADD R3,R2,R2
      drive(5, 5, 2, 1, 1, 0); tick();
      drive(2, 2, 3, 1, 0, 0); #1;
      chk("load_use_stall", STALL_D, 1);
      tick();
      chk("stall_one_cycle", STALL_D, 0);
      chk("stall_bubble_ae", FORWARD_AE, 0);
      tick();
      chk("after_load_ae", FORWARD_AE, 1);
      chk("after_load_be", FORWARD_BE, 1);
`ifdef HAZARD_STATS_EN
      chk("stall_count_one", STALL_COUNT, 1);
`endif
      nops(2);
      // load-use coinciding with a taken branch
      drive(5, 5, 2, 1, 1, 0); tick();
      drive(2, 2, 3, 1, 0, 1); #1;
      chk("branch_wins_stall", STALL_D, 0);
      chk("branch_flush", FLUSH_D, 1);
      tick();
      chk("branch_ae", FORWARD_AE, 0);
      chk("branch_be", FORWARD_BE, 0);
      nops(2);
      // R15 is never forwarded nor stalled on
      drive(0, 0, 15, 1, 0, 0); tick();
      drive(15, 15, 3, 1, 0, 0); tick();
      chk("pc_ae", FORWARD_AE, 0);
      chk("pc_be", FORWARD_BE, 0);
      drive(0, 0, 15, 1, 1, 0); tick();
      drive(15, 15, 3, 1, 0, 0); #1;
      chk("pc_no_stall", STALL_D, 0);
      nops(2);
      // reset in the middle of a load-use stall
      drive(5, 5, 2, 1, 1, 0); tick();
      drive(2, 2, 3, 1, 0, 0); #1;
      chk("pre_reset_stall", STALL_D, 1);
      RESET_N = 0;
      #1;
      chk("reset_stall_low", STALL_D, 0);
      chk("reset_ae_low", FORWARD_AE, 0);
      BRANCH_TAKEN_E = 1;
      #1;
      chk("reset_flush_low", FLUSH_D, 0);
      BRANCH_TAKEN_E = 0;
      tick();
      RESET_N = 1;
      #1;
      chk("release_no_stall", STALL_D, 0);
      tick();
      chk("release_ae", FORWARD_AE, 0);
      nops(3);
      active = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
